spi_bus_monitor: RTL
====================

SPI_BUS_MONITOR -- requirements
Module: spi_bus_monitor

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth in entries (power of 2, 2..16).
- REQ-002 SHALL have port Clk_i  input  1  single clock for all logic; one clock, reset synchronous active-low.
- REQ-003 SHALL have port Rst_ni  input  1  synchronous active-low reset, sampled on rising Clk_i.
- REQ-004 SHALL have port sck  input  1  SPI serial clock, asynchronous to Clk_i.
- REQ-005 SHALL have port mosi  input  1  SPI master-out data, asynchronous.
- REQ-006 SHALL have port miso  input  1  SPI slave-out data, asynchronous.
- REQ-007 SHALL have port ss  input  2  slave selects, one-hot active-high, asynchronous.
- REQ-008 SHALL have port rec_valid  output  1  FIFO head record available.
- REQ-009 SHALL have port rec_ready  input  1  consumer accepts head record.
- REQ-010 SHALL have port rec_mosi  output  8  head record master-to-slave byte.
- REQ-011 SHALL have port rec_miso  output  8  head record slave-to-master byte.
- REQ-012 SHALL have port rec_id  output  1  head record slave index (0 for ss=01, 1 for ss=10).
- REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on aborted or illegal frame.
- REQ-014 SHALL have port overflow  output  1  sticky flag, record dropped because FIFO full.
- REQ-015 SHALL have port ovf_clr  input  1  clears overflow.

Function
- REQ-016 SHALL pass sck, mosi, miso, ss each through a 2-flop synchronizer before use.
- REQ-017 SHALL sample synchronized mosi and miso on each synchronized rising sck edge (SPI mode 0), MSB first.
- REQ-018 SHALL implement states IDLE (ss==00), SHIFT (ss one-hot), ILLEGAL (ss==11).
- REQ-019 SHALL go IDLE->SHIFT on ss becoming one-hot, clearing 3-bit bit counter and latching rec_id.
- REQ-020 SHALL, on 8th sampled edge in SHIFT, push {id, mosi byte, miso byte} and restart bit counter, staying in SHIFT (back-to-back bytes allowed).
- REQ-021 SHALL, on ss leaving one-hot with bit counter != 0, discard partial byte and pulse frame_err.
- REQ-022 SHALL, on ss changing directly between 01 and 10, act as deassert then assert (REQ-021 applies, new id latched).
- REQ-023 SHALL enter ILLEGAL on ss==11, pulse frame_err once on entry, ignore sck until ss==00.
- REQ-024 SHALL assert rec_valid within 4 Clk_i cycles after 8th sck rising edge at pins, FIFO previously empty.
- REQ-025 SHALL pop head when rec_valid && rec_ready on rising Clk_i; rec_* hold stable while rec_valid && !rec_ready.
- REQ-026 SHALL, on push when full with simultaneous pop, perform both, leaving count unchanged, no overflow.
- REQ-027 SHALL, on push when full without pop, drop new record and set overflow.
- REQ-028 SHALL clear overflow on ovf_clr; set takes priority when both occur in the same cycle.
- REQ-029 SHALL require sck high and low phases each >= 3 Clk_i periods; faster sck is unsupported.

Reset
- REQ-030 SHALL, while Rst_ni low at rising Clk_i, enter IDLE, empty FIFO, clear bit counter and synchronizers.
- REQ-031 SHALL hold rec_valid=0, rec_mosi=0, rec_miso=0, rec_id=0, frame_err=0, overflow=0 in reset.
- REQ-032 SHALL, on reset mid-frame, discard partial byte with no frame_err; after release, ignore sck until ss observed 00.

Configuration
- REQ-033 SHALL, with SPIMON_ERRCNT_EN defined, add output err_cnt, 8 bits, incremented per frame_err pulse, saturating at 255, cleared by reset and ovf_clr.
- REQ-034 SHALL, without SPIMON_ERRCNT_EN, omit err_cnt and all its logic; other behaviour identical.

Verification
- REQ-035 SHALL cover: ss=01, mosi byte 8'hA5, miso 8'h3C, rec_ready=1 -> one record id=0, mosi=A5, miso=3C, frame_err never pulses.
- REQ-036 SHALL cover: ss=10, two back-to-back bytes 8'h01, 8'h80 -> two records id=1 in order 01, 80.
- REQ-037 SHALL cover: ss=01, 5 sck edges then ss=00 -> single frame_err pulse, no record, err_cnt=1 if enabled.
- REQ-038 SHALL cover: rec_ready=0, DEPTH+1 bytes sent -> DEPTH records kept, last dropped, overflow=1; ovf_clr -> overflow=0.
- REQ-039 SHALL cover: ss=11 for 16 sck edges -> one frame_err pulse, no records; then ss=01 byte 8'hFF -> record FF.
- REQ-040 SHALL cover: Rst_ni low after 4 sck edges of a frame -> all outputs 0, no record, no frame_err.

Source files
------------

// File: rtl/spi_bus_monitor.sv
// spi_bus_monitor: passive SPI (mode 0) sniffer for two slaves. It captures
// each complete byte as {slave id, mosi byte, miso byte} into a record FIFO.
// Optional feature macro: SPIMON_ERRCNT_EN adds an 8-bit saturating err_cnt
// output that counts frame_err pulses.
module spi_bus_monitor #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       Clk_i,
  input  logic       Rst_ni,
  input  logic       sck,
  input  logic       mosi,
  input  logic       miso,
  input  logic [1:0] ss,
  output logic       rec_valid,
  input  logic       rec_ready,
  output logic [7:0] rec_mosi,
  output logic [7:0] rec_miso,
  output logic       rec_id,
  output logic       frame_err,
  output logic       overflow,
`ifdef SPIMON_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  input  logic       ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic       id;
    logic [7:0] mosi;
    logic [7:0] miso;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ILLEGAL} state_e;

  // Synchronizers, edge history and arming
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       sck_prev_q, sck_prev_d;
  logic [1:0] prime_q, prime_d;
  logic       armed_q, armed_d;

  // Frame FSM and shifters
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       id_q, id_d;
  logic [7:0] mosi_sr_q, mosi_sr_d, miso_sr_q, miso_sr_d;
  logic       frame_err_q, frame_err_d;
  logic       push;
  logic       sck_rise;
  rec_t       rec_new;

  // Record FIFO
  rec_t       mem_q [DEPTH];
  rec_t       mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rec_t       head_q, head_d;
  logic       rec_valid_q, rec_valid_d;
  logic       overflow_q, overflow_d;
  logic       pop, full, push_ok;

  logic       sck_s, mosi_s, miso_s;
  logic [1:0] ss_s;

  assign sck_s  = sync2_q[0];
  assign mosi_s = sync2_q[1];
  assign miso_s = sync2_q[2];
  assign ss_s   = sync2_q[4:3];

  // Frame tracking: arming, bit sampling, byte completion and error detection
  always_comb begin
    sync1_d     = {ss, miso, mosi, sck};
    sync2_d     = sync1_q;
    sck_prev_d  = sck_s;
    prime_d     = {prime_q[0], 1'b1};
    armed_d     = armed_q | (prime_q[1] && (ss_s == 2'b00));
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    id_d        = id_q;
    mosi_sr_d   = mosi_sr_q;
    miso_sr_d   = miso_sr_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    sck_rise    = sck_s & ~sck_prev_q;

    case (state_q)
      S_IDLE: begin
        if (armed_q) begin
          if (ss_s == 2'b11) begin
            state_d     = S_ILLEGAL;
            frame_err_d = 1'b1;
          end else if (ss_s != 2'b00) begin
            state_d   = S_SHIFT;
            bit_cnt_d = 3'd0;
            id_d      = ss_s[1];
          end
        end
      end
      S_SHIFT: begin
        if (ss_s == 2'b00) begin
          state_d     = S_IDLE;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (ss_s == 2'b11) begin
          state_d     = S_ILLEGAL;
          frame_err_d = 1'b1;
        end else if (ss_s[1] != id_q) begin
          // Direct slave switch: close the old frame, open a new one
          frame_err_d = (bit_cnt_q != 3'd0);
          id_d        = ss_s[1];
          bit_cnt_d   = 3'd0;
        end else if (sck_rise) begin
          mosi_sr_d = {mosi_sr_q[6:0], mosi_s};
          miso_sr_d = {miso_sr_q[6:0], miso_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          push      = (bit_cnt_q == 3'd7);
        end
      end
      S_ILLEGAL: begin
        if (ss_s == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rec_new = '{id: id_q, mosi: mosi_sr_d, miso: miso_sr_d};
  end

  // FIFO pointers, storage, registered head and overflow flag
  always_comb begin
    pop        = rec_valid_q & rec_ready;
    full       = (count_q == CW'(DEPTH));
    push_ok    = push & (~full | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = rec_new;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    if (ovf_clr) overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;

    rec_valid_d = (count_d != '0);
    head_d      = rec_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sck_prev_q  <= 1'b0;
      prime_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      id_q        <= 1'b0;
      mosi_sr_q   <= '0;
      miso_sr_q   <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      rec_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sck_prev_q  <= sck_prev_d;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      id_q        <= id_d;
      mosi_sr_q   <= mosi_sr_d;
      miso_sr_q   <= miso_sr_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      rec_valid_q <= rec_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Record storage; contents are only observed through the reset head register
  always_ff @(posedge Clk_i) begin
    mem_q <= mem_d;
  end

`ifdef SPIMON_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating frame error counter
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ovf_clr)                                 err_cnt_d = '0;
    else if (frame_err_d && err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign rec_valid = rec_valid_q;
  assign rec_mosi  = head_q.mosi;
  assign rec_miso  = head_q.miso;
  assign rec_id    = head_q.id;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
